dec_pcm_out: RTL and testbench

//  Output stage directly downstream of the ADPCM decoder (dec). Accepts 14-bit linear

---
 rtl/dec_pcm_out.sv | 98 +++++++++
 tb/tb_dec_pcm_out.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dec_pcm_out.sv
// dec_pcm_out: G.711 u-law/A-law compression of decoded samples, code FIFO and serial PCM shifter
module dec_pcm_out #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_in0,
  input  logic        scan_en,
  output logic        scan_out0,
  input  logic [13:0] sr,
  input  logic        sr_valid,
  output logic        sr_ready,
  input  logic        law,
  input  logic        pcm_fs,
  input  logic        pcm_bit_en,
  output logic        pcm_sd,
  output logic        pcm_oe,
  output logic        underrun,
  output logic        fs_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic [7:0] sh, sh_d, code;
  logic [2:0] cnt, cnt_d;
  logic [14:0] sx, mag;
  logic [12:0] ub;
  logic [11:0] p;
  logic [2:0] useg, aseg;
  logic [3:0] umant, amant;
  logic full, empty, push;
  logic unused_scan;
  assign scan_out0 = 1'b0;
  assign unused_scan = scan_in0 ^ scan_en;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign sr_ready = !full;
  assign push = sr_valid && !full;
  assign pcm_oe = state == SHIFT;
  assign pcm_sd = pcm_oe && sh[7];
  // magnitude kept at 15 bits so that -8192 negates without overflow
  assign sx = {sr[13], sr};
  assign mag = sr[13] ? -sx : sx;
  assign ub = 13'(mag > 15'd8158 ? 15'd8158 : mag) + 13'd33;
  assign p = sr[13] ? ~sr[12:1] : sr[12:1];
  always_comb begin
    useg = 3'd0;
    aseg = 3'd0;
    for (int i = 5; i < 13; i++) if (ub[i]) useg = 3'(i - 5);
    for (int i = 5; i < 12; i++) if (p[i]) aseg = 3'(i - 4);
    umant = 4'(ub >> ({1'b0, useg} + 4'd1));
    amant = aseg < 3'd2 ? 4'(p >> 1) : 4'(p >> aseg);
    code = law ? {aseg, amant} ^ (sr[13] ? 8'h55 : 8'hD5)
               : {useg, umant} ^ (sr[13] ? 8'h7F : 8'hFF);
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= code;
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pcm_fs && !empty) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
      underrun <= 1'b0;
      fs_err <= 1'b0;
    end else begin
      state <= state_d;
      sh <= sh_d;
      cnt <= cnt_d;
      if (pcm_fs && empty) underrun <= 1'b1;
      if (pcm_fs && state == SHIFT) fs_err <= 1'b1;
    end
  end
  // frame sync always wins over the bit strobe and restarts the shifter
  always_comb begin
    state_d = state;
    sh_d = sh;
    cnt_d = cnt;
    if (pcm_fs) begin
      state_d = SHIFT;
      sh_d = empty ? (law ? 8'hD5 : 8'hFF) : mem[rp[AW-1:0]];
      cnt_d = 3'd0;
    end else if (state == SHIFT && pcm_bit_en) begin
      state_d = cnt == 3'd7 ? IDLE : SHIFT;
      sh_d = cnt == 3'd7 ? sh : {sh[6:0], 1'b0};
      cnt_d = cnt == 3'd7 ? cnt : cnt + 3'd1;
    end
  end
endmodule

// File: tb/tb_dec_pcm_out.sv
// tb_dec_pcm_out: directed vectors with hand-computed G.711 codes and FIFO/frame behaviour
module tb_dec_pcm_out;
  logic clk = 1'b0, reset = 1'b1, scan_in0 = 1'b0, scan_en = 1'b0, scan_out0;
  logic [13:0] sr = '0;
  logic sr_valid = 1'b0, sr_ready, law = 1'b0, pcm_fs = 1'b0, pcm_bit_en = 1'b0;
  logic pcm_sd, pcm_oe, underrun, fs_err;
  int checks = 0, failures = 0;
  logic [7:0] c;
  dec_pcm_out #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .scan_in0(scan_in0), .scan_en(scan_en), .scan_out0(scan_out0),
    .sr(sr), .sr_valid(sr_valid), .sr_ready(sr_ready), .law(law), .pcm_fs(pcm_fs),
    .pcm_bit_en(pcm_bit_en), .pcm_sd(pcm_sd), .pcm_oe(pcm_oe), .underrun(underrun), .fs_err(fs_err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [13:0] v);
    sr = v;
    sr_valid = 1'b1;
    tick;
    sr_valid = 1'b0;
  endtask
  task automatic shift_out(output logic [7:0] code);
    logic oe_all;
    oe_all = 1'b1;
    code = '0;
    for (int i = 0; i < 8; i++) begin
      code = {code[6:0], pcm_sd};
      oe_all &= pcm_oe;
      pcm_bit_en = 1'b1;
      tick;
      pcm_bit_en = 1'b0;
    end
    check("oe_during_frame", oe_all, 1);
    check("oe_after_frame", pcm_oe, 0);
  endtask
  task automatic frame(output logic [7:0] code);
    pcm_fs = 1'b1;
    tick;
    pcm_fs = 1'b0;
    shift_out(code);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask
  initial begin
    do_reset;
    check("rst_ready", sr_ready, 1);
    check("rst_oe", pcm_oe, 0);
    check("rst_sd", pcm_sd, 0);
    check("rst_underrun", underrun, 0);
    check("rst_fs_err", fs_err, 0);
    // u-law codes
    law = 1'b0;
    push(14'd0);
    push(14'd8191);
    push(-14'sd1);
    frame(c); check("ulaw_0", c, 8'hFF);
    frame(c); check("ulaw_8191", c, 8'h80);
    frame(c); check("ulaw_m1", c, 8'h7E);
    check("ulaw_no_underrun", underrun, 0);
    // A-law codes, four pushes fill the FIFO
    law = 1'b1;
    push(14'd0);
    push(14'd8191);
    push(-14'sd2);
    push(14'h2000);
    check("alaw_full_ready", sr_ready, 0);
    frame(c); check("alaw_0", c, 8'hD5);
    frame(c); check("alaw_8191", c, 8'hAA);
    frame(c); check("alaw_m2", c, 8'h55);
    frame(c); check("alaw_m8192", c, 8'h2A);
    check("alaw_no_underrun", underrun, 0);
    check("alaw_no_fs_err", fs_err, 0);
    // FIFO full backpressure
    law = 1'b0;
    push(14'd0);
    push(14'd8191);
    push(-14'sd1);
    check("fill3_ready", sr_ready, 1);
    push(14'd0);
    check("fill4_ready", sr_ready, 0);
    sr = 14'd8191;
    sr_valid = 1'b1;
    tick;
    check("held_ready", sr_ready, 0);
    pcm_fs = 1'b1;
    tick;
    pcm_fs = 1'b0;
    check("after_pop_ready", sr_ready, 1);
    tick;
    sr_valid = 1'b0;
    check("fifth_accepted_ready", sr_ready, 0);
    shift_out(c); check("full_q0", c, 8'hFF);
    frame(c); check("full_q1", c, 8'h80);
    frame(c); check("full_q2", c, 8'h7E);
    frame(c); check("full_q3", c, 8'hFF);
    frame(c); check("full_q4", c, 8'h80);
    check("full_no_underrun", underrun, 0);
    // underrun, sticky
    do_reset;
    law = 1'b0;
    frame(c); check("underrun_code", c, 8'hFF);
    check("underrun_set", underrun, 1);
    tick;
    tick;
    check("underrun_sticky", underrun, 1);
    check("underrun_no_fs_err", fs_err, 0);
    // fs during shift
    push(-14'sd1);
    push(14'd8191);
    pcm_fs = 1'b1;
    tick;
    pcm_fs = 1'b0;
    check("fs1_bit7", pcm_sd, 0);
    for (int i = 0; i < 3; i++) begin
      pcm_bit_en = 1'b1;
      tick;
      pcm_bit_en = 1'b0;
    end
    check("fs_err_before", fs_err, 0);
    check("mid_bit4", pcm_sd, 1);
    pcm_fs = 1'b1;
    tick;
    pcm_fs = 1'b0;
    check("fs_err_set", fs_err, 1);
    check("fs2_oe", pcm_oe, 1);
    check("fs2_bit7", pcm_sd, 1);
    shift_out(c); check("fs2_code", c, 8'h80);
    check("fs_err_sticky", fs_err, 1);
    check("underrun_still", underrun, 1);
    // reset mid-shift with codes queued
    push(-14'sd1);
    push(14'd8191);
    push(-14'sd1);
    pcm_fs = 1'b1;
    tick;
    pcm_fs = 1'b0;
    pcm_bit_en = 1'b1;
    tick;
    tick;
    pcm_bit_en = 1'b0;
    check("pre_reset_oe", pcm_oe, 1);
    reset = 1'b1;
    tick;
    check("mid_reset_oe", pcm_oe, 0);
    check("mid_reset_ready", sr_ready, 1);
    check("mid_reset_flags", {underrun, fs_err}, 0);
    reset = 1'b0;
    frame(c); check("post_reset_idle", c, 8'hFF);
    check("post_reset_underrun", underrun, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
